// File: rtl/pll_reset_seq.sv
// Staged reset sequencer driven by a synchronised PLL lock flag.
// Lock-loss statistics are built only when PLL_RESET_STATUS_EN is defined.
module pll_reset_seq #(
   parameter int LOCK_CYCLES = 1024,
   parameter int STAGES      = 3,
   parameter int STAGE_GAP   = 16,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   locked,
   input  logic                   clear_status,
   output logic [STAGES-1:0]      reset_out,
   output logic                   ready,
   output logic [1:0]             state,
   output logic [COUNT_WIDTH-1:0] lock_loss_count,
   output logic                   lock_lost
);

   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam int GW = $clog2(STAGE_GAP + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t            st;
   logic              lock_m;
   logic              lock_s;
   logic [LW-1:0]     lock_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [STAGES-1:0] next_out;

   // Shifting in a zero releases the next stage, lowest bit first
   assign next_out = reset_out << 1;
   assign state    = st;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= locked;
         lock_s <= lock_m;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st        <= WAIT_LOCK;
         reset_out <= '1;
         ready     <= 1'b0;
         lock_cnt  <= '0;
         gap_cnt   <= '0;
      end else if (st != WAIT_LOCK && !lock_s) begin
         st        <= WAIT_LOCK;
         reset_out <= '1;
         ready     <= 1'b0;
         lock_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         unique case (st)
            WAIT_LOCK: begin
               lock_cnt <= '0;
               if (lock_s) st <= STABILIZE;
            end
            STABILIZE: begin
               if (lock_cnt == LOCK_LAST) begin
                  reset_out <= next_out;
                  gap_cnt   <= '0;
                  if (STAGES == 1) begin
                     st    <= RUN;
                     ready <= 1'b1;
                  end else begin
                     st <= RELEASE;
                  end
               end else begin
                  lock_cnt <= lock_cnt + LW'(1);
               end
            end
            RELEASE: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt   <= '0;
                  reset_out <= next_out;
                  if (next_out == '0) begin
                     st    <= RUN;
                     ready <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            RUN: begin
               st <= RUN;
            end
            default: st <= WAIT_LOCK;
         endcase
      end
   end

`ifdef PLL_RESET_STATUS_EN
   logic loss_event;

   // Loss while still stabilising is a glitch, not an event
   assign loss_event = !lock_s && (st == RELEASE || st == RUN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_loss_count <= '0;
         lock_lost       <= 1'b0;
      end else if (clear_status) begin
         lock_loss_count <= loss_event ? COUNT_WIDTH'(1) : '0;
         lock_lost       <= loss_event;
      end else if (loss_event) begin
         if (lock_loss_count != '1)
            lock_loss_count <= lock_loss_count + COUNT_WIDTH'(1);
         lock_lost <= 1'b1;
      end
   end
`else
   logic unused_clear;

   assign unused_clear    = clear_status;
   assign lock_loss_count = '0;
   assign lock_lost       = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq (LOCK_CYCLES=8, STAGES=3, STAGE_GAP=4).
// Statistic expectations follow PLL_RESET_STATUS_EN when it is defined.
module tb_pll_reset_seq;

`ifdef PLL_RESET_STATUS_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       locked = 1'b0;
   logic       clear_status = 1'b0;
   logic [2:0] reset_out;
   logic       ready;
   logic [1:0] state;
   logic [7:0] lock_loss_count;
   logic       lock_lost;

   int total = 0;
   int bad   = 0;

   pll_reset_seq #(
      .LOCK_CYCLES(8),
      .STAGES(3),
      .STAGE_GAP(4),
      .COUNT_WIDTH(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .locked(locked),
      .clear_status(clear_status),
      .reset_out(reset_out),
      .ready(ready),
      .state(state),
      .lock_loss_count(lock_loss_count),
      .lock_lost(lock_lost)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cyc;
      logic       lk;
      logic [2:0] rst;
      logic       rdy;
      logic [1:0] st;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [2:0] r,
                          input logic rd, input logic [1:0] s);
      chk({nm, ".reset_out"}, int'(reset_out), int'(r));
      chk({nm, ".ready"}, int'(ready), int'(rd));
      chk({nm, ".state"}, int'(state), int'(s));
   endtask

   task automatic chk_stat(input string nm, input int cnt, input int lost);
      chk({nm, ".count"}, int'(lock_loss_count), EN ? cnt : 0);
      chk({nm, ".lost"}, int'(lock_lost), EN ? lost : 0);
   endtask

   // Caller arranges for edge N to be the next rising edge
   task automatic run_table(input string nm);
      int e;
      @(posedge clock);
      e = 0;
      for (int i = 0; i < 8; i++) begin
         while (e < tbl[i].cyc) begin
            @(posedge clock);
            e++;
         end
         #1;
         chk_out($sformatf("%s.e%0d", nm, tbl[i].cyc),
                 tbl[i].rst, tbl[i].rdy, tbl[i].st);
         locked = tbl[i].lk;
      end
   endtask

   // Lock, reach RELEASE, then drop lock: one counted event
   task automatic loss_in_release();
      @(negedge clock);
      locked = 1'b1;
      repeat (11) @(posedge clock);
      @(negedge clock);
      locked = 1'b0;
      repeat (3) @(posedge clock);
   endtask

   initial begin
      int e;
      tbl[0] = '{1,  1'b1, 3'b111, 1'b0, 2'd0};
      tbl[1] = '{2,  1'b1, 3'b111, 1'b0, 2'd1};
      tbl[2] = '{9,  1'b1, 3'b111, 1'b0, 2'd1};
      tbl[3] = '{10, 1'b1, 3'b110, 1'b0, 2'd2};
      tbl[4] = '{13, 1'b1, 3'b110, 1'b0, 2'd2};
      tbl[5] = '{14, 1'b1, 3'b100, 1'b0, 2'd2};
      tbl[6] = '{17, 1'b1, 3'b100, 1'b0, 2'd2};
      tbl[7] = '{18, 1'b1, 3'b000, 1'b1, 2'd3};

      repeat (2) @(posedge clock);
      #1;
      chk_out("rst", 3'b111, 1'b0, 2'd0);
      chk_stat("rst", 0, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk_out("nolock", 3'b111, 1'b0, 2'd0);

      @(negedge clock);
      locked = 1'b1;
      run_table("seq");

      @(negedge clock);
      locked = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_out("runloss.m1", 3'b000, 1'b1, 2'd3);
      @(posedge clock);
      #1;
      chk_out("runloss.m2", 3'b111, 1'b0, 2'd0);
      chk_stat("runloss", 1, 1);

      @(negedge clock);
      locked = 1'b1;
      @(posedge clock);
      e = 0;
      repeat (5) begin
         @(posedge clock);
         e++;
      end
      #1;
      chk_out("glitch.e5", 3'b111, 1'b0, 2'd1);
      @(negedge clock);
      locked = 1'b0;
      @(negedge clock);
      locked = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk_out("glitch.e8", 3'b111, 1'b0, 2'd0);
      chk_stat("glitch", 1, 1);
      repeat (8) @(posedge clock);
      #1;
      chk_out("glitch.e16", 3'b111, 1'b0, 2'd1);
      @(posedge clock);
      #1;
      chk_out("glitch.e17", 3'b110, 1'b0, 2'd2);
      repeat (8) @(posedge clock);
      #1;
      chk_out("glitch.e25", 3'b000, 1'b1, 2'd3);

      @(negedge clock);
      locked = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk_stat("loss2", 2, 1);
      @(negedge clock);
      clear_status = 1'b1;
      @(negedge clock);
      clear_status = 1'b0;
      chk_stat("clear", 0, 0);

      repeat (5) loss_in_release();
      #1;
      chk_stat("five", 5, 1);
      chk_out("five", 3'b111, 1'b0, 2'd0);

      @(negedge clock);
      locked = 1'b1;
      repeat (11) @(posedge clock);
      @(negedge clock);
      locked = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      clear_status = 1'b1;
      @(negedge clock);
      clear_status = 1'b0;
      chk_stat("clr_evt", 1, 1);
      chk_out("clr_evt", 3'b111, 1'b0, 2'd0);

      repeat (300) loss_in_release();
      #1;
      chk_stat("sat", 255, 1);

      @(negedge clock);
      locked = 1'b1;
      repeat (13) @(posedge clock);
      #1;
      chk_out("pre_arst", 3'b110, 1'b0, 2'd2);
      #1;
      reset = 1'b1;
      #1;
      chk_out("arst", 3'b111, 1'b0, 2'd0);
      chk_stat("arst", 0, 0);
      @(negedge clock);
      reset = 1'b0;
      run_table("restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
